// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, requests from a synchronous SRAM (1-cycle fetch latency), holds the word for decode.
// Backpressure: while decode withholds allowin the instruction is held stable and no new request is issued.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin_in,
  input  logic        id_inst_valid_in,
  input  logic        br_taken_in,
  input  logic [31:0] br_target_in,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_valid_out,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NNPC_out,
  output logic [31:0] if_Instruct_out
);

  typedef enum logic {RUN, DS_WAIT} br_state_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] tgt_q, tgt_d;
  logic        valid_q, valid_d;
  logic        from_sram_q, from_sram_d;
  br_state_t   br_state_q, br_state_d;

  logic        redirect_now, ds_redirect, hs, acc, fetch;
  logic [31:0] fetch_addr;

  always_comb begin
    // Delay slot already sits in decode, so whatever IF holds is on the wrong path.
    redirect_now = (br_state_q == RUN) && br_taken_in && id_inst_valid_in;
    if_valid_out = valid_q && !redirect_now;
    hs           = if_valid_out && id_allowin_in;
    ds_redirect  = (br_state_q == DS_WAIT) && hs;
    acc          = !valid_q || hs || redirect_now;
    fetch        = acc && !rst;
    if (redirect_now)     fetch_addr = br_target_in;
    else if (ds_redirect) fetch_addr = tgt_q;
    else                  fetch_addr = pc_q + 32'd4;
  end

  assign inst_sram_en    = fetch;
  assign inst_sram_addr  = fetch_addr;
  assign if_PC_out       = pc_q;
  assign if_NNPC_out     = pc_q + 32'd8;
  assign if_Instruct_out = from_sram_q ? inst_sram_rdata : inst_buf_q;

  always_comb begin
    pc_d        = pc_q;
    inst_buf_d  = inst_buf_q;
    tgt_d       = tgt_q;
    valid_d     = valid_q;
    from_sram_d = from_sram_q;
    br_state_d  = br_state_q;

    // SRAM data is only valid for one cycle; capture it if decode did not take it.
    if (from_sram_q && !hs) begin
      inst_buf_d  = inst_sram_rdata;
      from_sram_d = 1'b0;
    end

    if (fetch) begin
      pc_d        = fetch_addr;
      valid_d     = 1'b1;
      from_sram_d = 1'b1;
    end else if (hs) begin
      valid_d = 1'b0;
    end

    case (br_state_q)
      RUN: begin
        if (br_taken_in && !id_inst_valid_in) begin
          tgt_d      = br_target_in;
          br_state_d = DS_WAIT;
        end
      end
      DS_WAIT: begin
        if (hs) br_state_d = RUN;
      end
      default: br_state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC - 32'd4;
      inst_buf_q  <= 32'd0;
      tgt_q       <= 32'd0;
      valid_q     <= 1'b0;
      from_sram_q <= 1'b0;
      br_state_q  <= RUN;
    end else begin
      pc_q        <= pc_d;
      inst_buf_q  <= inst_buf_d;
      tgt_q       <= tgt_d;
      valid_q     <= valid_d;
      from_sram_q <= from_sram_d;
      br_state_q  <= br_state_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic against a cycle reference model with a handoff scoreboard.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_allowin_in = 1'b0;
  logic        id_inst_valid_in = 1'b0;
  logic        br_taken_in = 1'b0;
  logic [31:0] br_target_in = 32'd0;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'd0;
  logic        if_valid_out;
  logic [31:0] if_PC_out, if_NNPC_out, if_Instruct_out;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];

  bit          m_valid = 1'b0;
  bit          m_ds = 1'b0;
  bit          m_ready = 1'b0;
  bit          m_prev_rst = 1'b0;
  logic [31:0] m_pc = RST_PC - 32'd4;
  logic [31:0] m_tgt = 32'd0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_allowin_in   (id_allowin_in),
    .id_inst_valid_in(id_inst_valid_in),
    .br_taken_in     (br_taken_in),
    .br_target_in    (br_target_in),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .if_valid_out    (if_valid_out),
    .if_PC_out       (if_PC_out),
    .if_NNPC_out     (if_NNPC_out),
    .if_Instruct_out (if_Instruct_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // SRAM returns garbage on idle cycles so a stale read-data path cannot pass.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : $urandom;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every instruction decode accepts must be the next one the model expects.
  always @(negedge clk) begin
    if (if_valid_out === 1'b1 && id_allowin_in === 1'b1) begin
      logic [31:0] pc, nnpc, inst, e;
      pc = if_PC_out; nnpc = if_NNPC_out; inst = if_Instruct_out;
      #1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL hs_unexpected: got handoff pc %h expected none", pc);
      end else begin
        e = exp_q.pop_front();
        chk("hs_pc", pc, e);
        chk("hs_nnpc", nnpc, e + 32'd8);
        chk("hs_inst", inst, mem_word(e));
      end
    end
  end

  task automatic step(input bit r, input bit al, input bit iv, input bit br, input logic [31:0] tg);
    bit kill, vis, hs, take;
    logic [31:0] addr;
    @(posedge clk);
    #1;
    rst = r; id_allowin_in = al; id_inst_valid_in = iv; br_taken_in = br; br_target_in = tg;
    assert (!(br && m_ds && !r)) else $error("branch issued while delay slot pending");
    @(negedge clk);
    kill = !m_ds && br && iv;
    vis  = m_valid && !kill;
    hs   = vis && al;
    take = !r && (!m_valid || hs || kill);
    if (kill)            addr = tg;
    else if (m_ds && hs) addr = m_tgt;
    else                 addr = m_pc + 32'd4;
    if (m_ready) begin
      chk("sram_en", {31'd0, inst_sram_en}, {31'd0, take});
      if (take) chk("sram_addr", inst_sram_addr, addr);
      chk("if_valid", {31'd0, if_valid_out}, {31'd0, vis});
      if (m_valid) begin
        chk("hold_pc", if_PC_out, m_pc);
        chk("hold_nnpc", if_NNPC_out, m_pc + 32'd8);
        chk("hold_inst", if_Instruct_out, mem_word(m_pc));
      end
      if (m_prev_rst) begin
        chk("rst_pc", if_PC_out, 32'hBFBF_FFFC);
        chk("rst_nnpc", if_NNPC_out, 32'hBFC0_0004);
        chk("rst_inst", if_Instruct_out, 32'd0);
        chk("rst_valid", {31'd0, if_valid_out}, 32'd0);
      end
    end
    if (hs) exp_q.push_back(m_pc);
    if (r) begin
      m_valid = 1'b0; m_pc = RST_PC - 32'd4; m_ds = 1'b0;
    end else begin
      if (take) begin m_valid = 1'b1; m_pc = addr; end
      else if (hs) m_valid = 1'b0;
      if (m_ds && hs) m_ds = 1'b0;
      else if (!m_ds && br && !iv) begin m_ds = 1'b1; m_tgt = tg; end
    end
    m_prev_rst = r;
    m_ready = 1'b1;
  endtask

  initial begin
    repeat (3) step(1, 0, 0, 0, 32'd0);
    // Streaming: BFC0_0000, _0004 handed off, _0008 left in IF.
    repeat (3) step(0, 1, 0, 0, 32'd0);
    // Decode stall with BFC0_0008 held, then release.
    repeat (3) step(0, 0, 0, 0, 32'd0);
    repeat (2) step(0, 1, 0, 0, 32'd0);
    // IF holds BFC0_0010 as delay slot; branch resolves with decode empty.
    step(0, 0, 0, 1, 32'h8000_0200);
    repeat (2) step(0, 0, 0, 0, 32'd0);
    step(0, 1, 0, 0, 32'd0);
    step(0, 1, 1, 0, 32'd0);
    // Delay slot already in decode: kill IF and redirect immediately.
    step(0, 1, 1, 1, 32'h8000_0100);
    step(0, 1, 1, 0, 32'd0);
    // Reset coincident with a redirect.
    step(1, 1, 1, 1, 32'h1234_5678);
    step(1, 1, 0, 0, 32'd0);
    repeat (3) step(0, 1, 0, 0, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      bit r, al, iv, br;
      r  = ($urandom_range(0, 99) == 0);
      al = ($urandom_range(0, 3) != 0);
      iv = ($urandom_range(0, 1) == 1);
      br = !m_ds && ($urandom_range(0, 5) == 0);
      step(r, al, iv, br, $urandom);
    end
    step(0, 0, 0, 0, 32'd0);
    #2;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the decode stage. It owns the PC, issues requests to a synchronous-read instruction SRAM, and holds each fetched instruction until decode accepts it through the valid/allowin handshake. It applies taken-branch redirects from execute and honours the MIPS branch delay slot: the delay-slot instruction always reaches decode before the target is fetched.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first instruction fetched after reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- id_allowin_in  in  1  decode can accept an instruction this cycle.
- id_inst_valid_in  in  1  decode currently holds a valid instruction (its valid register).
- br_taken_in  in  1  one-cycle pulse from execute: taken branch/jump resolved.
- br_target_in  in  32  redirect target, sampled when br_taken_in=1.
- inst_sram_en  out  1  fetch request this cycle.
- inst_sram_addr  out  32  fetch address; data returns next cycle.
- inst_sram_rdata  in  32  SRAM read data, valid the cycle after a request.
- if_valid_out  out  1  IF holds an instruction for decode.
- if_PC_out  out  32  PC of held instruction.
- if_NNPC_out  out  32  if_PC_out + 8.
- if_Instruct_out  out  32  held instruction word.

## Operation
- State: pc_r, valid_r, from_sram (request issued last cycle), inst_buf, br_state {RUN, DS_WAIT}, tgt_r.
- Handoff: hs = if_valid_out && id_allowin_in. IF accepts new fetch when acc = !valid_r || hs.
- Fetch: inst_sram_en = acc && !rst. Address: redirect-now ? br_target_in : ds-redirect ? tgt_r : pc_r+4 (32-bit wrap). On request: pc_r <= address, valid_r <= 1, from_sram <= 1. Else if hs: valid_r <= 0.
- Instruction source: if_Instruct_out = from_sram ? inst_sram_rdata : inst_buf. When from_sram=1 and !hs, inst_buf <= inst_sram_rdata, from_sram <= 0.
- Redirect, RUN state, br_taken_in=1:
  - id_inst_valid_in=1 (delay slot already in decode): redirect-now. Current IF instruction killed (if_valid_out forced 0 this cycle, hs=0), acc forced 1, request at br_target_in.
  - id_inst_valid_in=0: tgt_r <= br_target_in, go DS_WAIT; sequential fetch continues.
- DS_WAIT: first hs passes the delay slot; in that same cycle the request uses tgt_r (ds-redirect), state -> RUN.
- br_taken_in in DS_WAIT: not legal; ignored (bench asserts it never occurs).
- Addresses issued unaligned as given; alignment exceptions are decode's job.
- Reset: valid_r=0, from_sram=0, inst_buf=0, pc_r=RESET_PC-4, br_state=RUN. rst overrides redirect and handshake in the same cycle.

## Timing
- Reset values: if_valid_out=0, inst_sram_en=0, if_PC_out=32'hBFBF_FFFC, if_NNPC_out=32'hBFC0_0004, if_Instruct_out=0.
- First cycle after rst falls: request at RESET_PC; if_valid_out=1 next cycle.
- Throughput 1 instruction/cycle while decode keeps allowin high; fetch latency 1 cycle.
- Decode stall: PC/instruction held stable (from inst_buf after the first cycle), no new requests.
- Redirect-now: target instruction valid in IF one cycle after br_taken_in; one bubble.
- DS_WAIT: target valid one cycle after delay-slot handoff.
- if_valid_out combinationally depends on br_taken_in and id_inst_valid_in (kill path); all other outputs are register/SRAM driven.

## Test plan
- Reset release, id_allowin_in=1 constant, SRAM returns addr-derived words -> PCs BFC0_0000, _0004, _0008 on consecutive cycles, NNPC = PC+8, instruction matches each address.
- Decode stall 3 cycles with PC BFC0_0008 held -> no requests, if_PC_out/if_Instruct_out stable for all 3 cycles (second+ from inst_buf), next PC BFC0_000C after release.
- br_taken_in=1, target 8000_0100, id_inst_valid_in=1 -> IF instruction dropped (if_valid_out=0), request 8000_0100 same cycle, next cycle if_PC_out=8000_0100.
- br_taken_in=1, target 8000_0200, id_inst_valid_in=0, IF holds BFC0_0010 -> BFC0_0010 handed to decode, then 8000_0200; BFC0_0014 never issued.
- DS_WAIT with decode stalled 2 cycles -> delay slot held, target fetched only in handoff cycle.
- rst asserted mid-run coincident with br_taken_in -> reset values next cycle, refetch from BFC0_0000, redirect discarded.
